// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage hold vector, multi-cycle EX, RAM wait with timeout, flush.
// Stall is combinational from state and requests; flush, flush_pc_out, mem_timeout and state are registered.
module pipeline_ctrl #(
  parameter int EX_CNT_W = 6,
  parameter int MEM_TMO  = 255,
  parameter int TMO_W    = 8,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_stall_req,
  input  logic                id_stall_req,
  input  logic                ex_start,
  input  logic [EX_CNT_W-1:0] ex_cycles,
  input  logic                mem_req,
  input  logic                mem_ack,
  input  logic                flush_req,
  input  logic [ADDR_W-1:0]   flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [ADDR_W-1:0]   flush_pc_out,
  output logic                mem_timeout,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EX_BUSY  = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  localparam logic [5:0] IF_MASK  = 6'b000011;
  localparam logic [5:0] ID_MASK  = 6'b000111;
  localparam logic [5:0] EX_MASK  = 6'b001111;
  localparam logic [5:0] MEM_MASK = 6'b011111;

  localparam logic [TMO_W-1:0]    TMO_LIMIT = TMO_W'(MEM_TMO);
  localparam logic [EX_CNT_W-1:0] CNT_ONE   = EX_CNT_W'(1);

  state_t              cur;
  logic [EX_CNT_W-1:0] cnt;
  logic [TMO_W-1:0]    tmo;
  logic                pend_flush;
  logic [ADDR_W-1:0]   pend_pc;

  logic       mem_blocked;
  logic       ex_valid;
  logic       ex_long;
  logic       tmo_hit;
  logic       mem_done;
  logic [5:0] hazard;
  logic [5:0] stall_c;

  assign state       = cur;
  assign mem_blocked = mem_req & ~mem_ack;
  assign ex_valid    = ex_start & (ex_cycles != '0);
  assign ex_long     = ex_start & (ex_cycles > CNT_ONE);
  assign tmo_hit     = (cur == S_MEM_WAIT) & ~mem_ack & (tmo == TMO_LIMIT);
  assign mem_done    = (cur == S_MEM_WAIT) & (mem_ack | tmo_hit);
  assign hazard      = (if_stall_req ? IF_MASK : 6'b0) | (id_stall_req ? ID_MASK : 6'b0);

  // Hold nothing while in reset so the inter-stage registers clear cleanly.
  always_comb begin
    stall_c = 6'b0;
    case (cur)
      S_IDLE:     stall_c = hazard | (ex_valid ? EX_MASK : 6'b0) | (mem_blocked ? MEM_MASK : 6'b0);
      S_EX_BUSY:  stall_c = hazard | EX_MASK;
      S_MEM_WAIT: stall_c = mem_done ? hazard : MEM_MASK;
      S_FLUSH:    stall_c = 6'b0;
      default:    stall_c = 6'b0;
    endcase
    if (!rst) stall_c = 6'b0;
  end

  assign stall = stall_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur          <= S_IDLE;
      cnt          <= '0;
      tmo          <= '0;
      flush        <= 1'b0;
      flush_pc_out <= '0;
      mem_timeout  <= 1'b0;
      pend_flush   <= 1'b0;
      pend_pc      <= '0;
    end else begin
      flush       <= 1'b0;
      mem_timeout <= 1'b0;
      case (cur)
        S_IDLE: begin
          // An older instruction stuck in MEM must finish before a redirect takes effect.
          if (mem_blocked) begin
            cur <= S_MEM_WAIT;
            tmo <= TMO_W'(1);
            if (flush_req) begin
              pend_flush <= 1'b1;
              pend_pc    <= flush_pc;
            end
          end else if (flush_req) begin
            cur          <= S_FLUSH;
            flush        <= 1'b1;
            flush_pc_out <= flush_pc;
          end else if (ex_long) begin
            cur <= S_EX_BUSY;
            cnt <= ex_cycles - CNT_ONE;
          end
        end
        S_EX_BUSY: begin
          if (flush_req) begin
            cur          <= S_FLUSH;
            cnt          <= '0;
            flush        <= 1'b1;
            flush_pc_out <= flush_pc;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) cur <= S_IDLE;
          end
        end
        S_MEM_WAIT: begin
          if (mem_done) begin
            tmo         <= '0;
            mem_timeout <= tmo_hit;
            pend_flush  <= 1'b0;
            if (flush_req || pend_flush) begin
              cur          <= S_FLUSH;
              flush        <= 1'b1;
              flush_pc_out <= flush_req ? flush_pc : pend_pc;
            end else begin
              cur <= S_IDLE;
            end
          end else begin
            tmo <= tmo + TMO_W'(1);
            if (flush_req) begin
              pend_flush <= 1'b1;
              pend_pc    <= flush_pc;
            end
          end
        end
        S_FLUSH: begin
          if (flush_req) begin
            flush        <= 1'b1;
            flush_pc_out <= flush_pc;
          end else begin
            cur <= S_IDLE;
          end
        end
        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector table for pipeline_ctrl (MEM_TMO=8), plus a long multi-cycle EX sequence.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_stall_req, ex_start;
  logic [5:0]  ex_cycles;
  logic        mem_req, mem_ack, flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc_out;
  logic        mem_timeout;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.EX_CNT_W(6), .MEM_TMO(8), .TMO_W(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .ex_start(ex_start), .ex_cycles(ex_cycles),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .flush_pc_out(flush_pc_out),
    .mem_timeout(mem_timeout), .state(state)
  );

  typedef struct {
    logic        rst, ifr, idr, exs;
    logic [5:0]  exc;
    logic        mreq, mack, freq;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_tmo;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic ifr, input logic idr, input logic exs,
                     input logic [5:0] exc, input logic mreq, input logic mack,
                     input logic freq, input logic [31:0] fpc,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep,
                     input logic et, input logic [1:0] est);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.idr = idr; v.exs = exs; v.exc = exc;
    v.mreq = mreq; v.mack = mack; v.freq = freq; v.fpc = fpc;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_tmo = et; v.e_state = est;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; if_stall_req = v.ifr; id_stall_req = v.idr;
    ex_start = v.exs; ex_cycles = v.exc;
    mem_req = v.mreq; mem_ack = v.mack; flush_req = v.freq; flush_pc = v.fpc;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; if_stall_req = 1'b0; id_stall_req = 1'b0; ex_start = 1'b0;
    ex_cycles = '0; mem_req = 1'b0; mem_ack = 1'b0; flush_req = 1'b0; flush_pc = '0;
  endtask

  initial begin
    // r ifr idr exs exc mreq mack freq fpc | stall flush pc tmo state
    // reset with every request high
    add(0,1,1,1,6'd4,1,0,1,32'hDEAD, 6'h00,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,0,32'h0,0,2'd0);
    // EX N=4
    add(1,0,0,1,6'd4,0,0,0,32'h0, 6'h0F,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h0F,0,32'h0,0,2'd1);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h0F,0,32'h0,0,2'd1);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h0F,0,32'h0,0,2'd1);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    // EX N=1 and N=0
    add(1,0,0,1,6'd1,0,0,0,32'h0, 6'h0F,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    add(1,0,0,1,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    // IF / ID hazards
    add(1,1,0,0,6'd0,0,0,0,32'h0, 6'h03,0,32'h0,0,2'd0);
    add(1,0,1,0,6'd0,0,0,0,32'h0, 6'h07,0,32'h0,0,2'd0);
    add(1,1,1,0,6'd0,0,0,0,32'h0, 6'h07,0,32'h0,0,2'd0);
    // MEM ack after 3 cycles, then same-cycle ack
    add(1,0,0,0,6'd0,1,0,0,32'h0, 6'h1F,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,1,0,0,32'h0, 6'h1F,0,32'h0,0,2'd2);
    add(1,0,0,0,6'd0,1,0,0,32'h0, 6'h1F,0,32'h0,0,2'd2);
    add(1,0,0,0,6'd0,1,1,0,32'h0, 6'h00,0,32'h0,0,2'd2);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,1,1,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    // MEM timeout: 8 stalled cycles, release, then 1-cycle pulse
    add(1,0,0,0,6'd0,1,0,0,32'h0, 6'h1F,0,32'h0,0,2'd0);
    for (int i = 0; i < 7; i++) add(1,0,0,0,6'd0,1,0,0,32'h0, 6'h1F,0,32'h0,0,2'd2);
    add(1,0,0,0,6'd0,1,0,0,32'h0, 6'h00,0,32'h0,0,2'd2);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,1,2'd0);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    // flush aborting EX_BUSY at cnt=3; IF/ID ignored in FLUSH
    add(1,0,0,1,6'd5,0,0,0,32'h0,    6'h0F,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h0F,0,32'h0,0,2'd1);
    add(1,0,0,0,6'd0,0,0,1,32'h1000, 6'h0F,0,32'h0,0,2'd1);
    add(1,1,1,0,6'd0,0,0,0,32'h0,    6'h00,1,32'h1000,0,2'd3);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,0,32'h1000,0,2'd0);
    // back-to-back flush keeps flush high with latest PC
    add(1,0,0,0,6'd0,0,0,1,32'h2000, 6'h00,0,32'h1000,0,2'd0);
    add(1,0,0,0,6'd0,0,0,1,32'h3000, 6'h00,1,32'h2000,0,2'd3);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,1,32'h3000,0,2'd3);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,0,32'h3000,0,2'd0);
    // flush pending in MEM_WAIT, latest PC wins, FLUSH after ack
    add(1,0,0,0,6'd0,1,0,0,32'h0,    6'h1F,0,32'h3000,0,2'd0);
    add(1,0,0,0,6'd0,1,0,1,32'h4000, 6'h1F,0,32'h3000,0,2'd2);
    add(1,0,0,0,6'd0,1,0,1,32'h5000, 6'h1F,0,32'h3000,0,2'd2);
    add(1,0,0,0,6'd0,1,1,0,32'h0,    6'h00,0,32'h3000,0,2'd2);
    add(1,1,1,0,6'd0,0,0,0,32'h0,    6'h00,1,32'h5000,0,2'd3);
    add(1,1,1,0,6'd0,0,0,0,32'h0,    6'h07,0,32'h5000,0,2'd0);
    // reset during MEM_WAIT with a pending flush
    add(1,0,0,0,6'd0,1,0,0,32'h0,    6'h1F,0,32'h5000,0,2'd0);
    add(1,0,0,0,6'd0,1,0,1,32'h6000, 6'h1F,0,32'h5000,0,2'd2);
    add(0,0,0,0,6'd0,1,0,0,32'h0,    6'h00,0,32'h5000,0,2'd2);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,0,32'h0,0,2'd0);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,0,32'h0,0,2'd0);
    // reset during EX_BUSY
    add(1,0,0,1,6'd8,0,0,0,32'h0, 6'h0F,0,32'h0,0,2'd0);
    add(0,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd1);
    add(1,0,0,0,6'd0,0,0,0,32'h0, 6'h00,0,32'h0,0,2'd0);
    // mem_req+flush_req in IDLE: flush waits for the timeout, then both fire
    add(1,0,0,0,6'd0,1,0,1,32'h7000, 6'h1F,0,32'h0,0,2'd0);
    for (int i = 0; i < 7; i++) add(1,0,0,0,6'd0,1,0,0,32'h0, 6'h1F,0,32'h0,0,2'd2);
    add(1,0,0,0,6'd0,1,0,0,32'h0,    6'h00,0,32'h0,0,2'd2);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,1,32'h7000,1,2'd3);
    add(1,0,0,0,6'd0,0,0,0,32'h0,    6'h00,0,32'h7000,0,2'd0);

    idle_inputs();
    rst = 1'b0; if_stall_req = 1'b1; id_stall_req = 1'b1; mem_req = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clk);
      n_cmp++;
      if (stall !== vq[i].e_stall || flush !== vq[i].e_flush || flush_pc_out !== vq[i].e_pc ||
          mem_timeout !== vq[i].e_tmo || state !== vq[i].e_state) begin
        n_err++;
        $display("FAIL vec%0d: got stall=%b flush=%b pc=%h tmo=%b state=%0d, want stall=%b flush=%b pc=%h tmo=%b state=%0d",
                 i, stall, flush, flush_pc_out, mem_timeout, state,
                 vq[i].e_stall, vq[i].e_flush, vq[i].e_pc, vq[i].e_tmo, vq[i].e_state);
      end
      @(posedge clk); #1;
    end

    // Long EX op: exactly 20 consecutive EX-stalled cycles, bounded at 64.
    begin
      int stalled;
      idle_inputs();
      ex_start = 1'b1; ex_cycles = 6'd20;
      stalled = 0;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (stall !== 6'h0F) break;
        stalled++;
        @(posedge clk); #1;
        ex_start = 1'b0; ex_cycles = '0;
      end
      n_cmp++;
      if (stalled != 20) begin
        n_err++;
        $display("FAIL ex20_len: got %0d stalled cycles, want 20", stalled);
      end
      n_cmp++;
      if (state !== 2'd0 || stall !== 6'h00) begin
        n_err++;
        $display("FAIL ex20_end: got state=%0d stall=%b, want state=0 stall=000000", state, stall);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
